// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU operation scheduler.
// Request/response bundles and the in-flight tracking entry.
package alu_sched_pkg;

    localparam int TAG_W       = 4;
    localparam int ALU_LATENCY = 2;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_ADD = 1'b1
    } op_e;

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        op_e              op;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        op_e              op;
    } rsp_t;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        op_e              op;
    } flight_t;

endpackage

// File: rtl/alu_sched_fifo.sv
// Synchronous FIFO with full/empty/count; push when full and pop
// when empty are ignored. Depth must be a power of two.
module alu_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full    = (cnt_q == (AW+1)'(DEPTH));
        empty   = (cnt_q == '0);
        count   = cnt_q;
        rdata   = mem_q[rptr_q];
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: only entries covered by count are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Queues tagged add/multiply requests, issues them to the ALU and
// returns results in order with credit-based response flow control.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [7:0]       i_req_a,
    input  logic [7:0]       i_req_b,
    input  logic             i_req_op,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic [7:0]       o_alu_data_A,
    output logic [7:0]       o_alu_data_B,
    output logic             o_alu_sel_op,
    input  logic [15:0]      i_alu_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [15:0]      o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_op,
    output logic             o_busy,
    output logic [15:0]      o_issued_cnt
);

    localparam int RQ_CW = $clog2(REQ_DEPTH) + 1;
    localparam int RS_CW = $clog2(RSP_DEPTH) + 1;

    req_t             req_wdata, req_head;
    rsp_t             rsp_wdata, rsp_head;
    logic             req_full, req_empty, req_push;
    logic             rsp_full, rsp_empty, rsp_push, rsp_pop;
    logic [RQ_CW-1:0] req_count;
    logic [RS_CW-1:0] rsp_count;
    logic             issue, inflight_any;
    int               inflight;

    flight_t [ALU_LATENCY-1:0] pipe_q, pipe_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic        sel_q, sel_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        req_wdata = '{a: i_req_a, b: i_req_b,
                      op: op_e'(i_req_op), tag: i_req_tag};
        req_push  = i_req_valid & ~req_full;
        inflight  = 0;
        for (int i = 0; i < ALU_LATENCY; i++) begin
            inflight = inflight + int'(pipe_q[i].v);
        end
        inflight_any = (inflight != 0);
        // Credits: results already queued plus those still in the ALU.
        issue = (req_count != '0) &&
                ((int'(rsp_count) + inflight) < RSP_DEPTH);

        pipe_d[0] = '0;
        a_d   = '0;
        b_d   = '0;
        sel_d = 1'b0;
        if (issue) begin
            pipe_d[0] = '{v: 1'b1, tag: req_head.tag, op: req_head.op};
            a_d   = req_head.a;
            b_d   = req_head.b;
            sel_d = req_head.op;
        end
        for (int i = 1; i < ALU_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        cnt_d = cnt_q + 16'(issue);

        rsp_push  = pipe_q[ALU_LATENCY-1].v & ~rsp_full;
        rsp_wdata = '{data: i_alu_data,
                      tag: pipe_q[ALU_LATENCY-1].tag,
                      op: pipe_q[ALU_LATENCY-1].op};
        rsp_pop   = i_rsp_ready & ~rsp_empty;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pipe_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
        end
    end

    alu_sched_fifo #(.W($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (req_push),
        .wdata (req_wdata),
        .pop   (issue),
        .rdata (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    alu_sched_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (rsp_push),
        .wdata (rsp_wdata),
        .pop   (rsp_pop),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    always_comb begin
        o_req_ready  = ~req_full;
        o_alu_data_A = a_q;
        o_alu_data_B = b_q;
        o_alu_sel_op = sel_q;
        o_rsp_valid  = ~rsp_empty;
        o_rsp_data   = rsp_empty ? '0 : rsp_head.data;
        o_rsp_tag    = rsp_empty ? '0 : rsp_head.tag;
        o_rsp_op     = rsp_empty ? 1'b0 : rsp_head.op;
        o_busy       = ~req_empty | inflight_any | ~rsp_empty;
        o_issued_cnt = cnt_q;
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed plus random checks of alu_op_scheduler against a queue-based
// reference model, with a behavioural two-register ALU attached.
module tb_alu_op_scheduler;

    logic        clk;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [7:0]  i_req_a, i_req_b;
    logic        i_req_op;
    logic [3:0]  i_req_tag;
    logic [7:0]  o_alu_data_A, o_alu_data_B;
    logic        o_alu_sel_op;
    logic [15:0] alu_q;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [15:0] o_rsp_data;
    logic [3:0]  o_rsp_tag;
    logic        o_rsp_op;
    logic        o_busy;
    logic [15:0] o_issued_cnt;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  t;
        logic        o;
    } exp_t;

    exp_t mq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_rsp    = 0;
    int   rsp_first, rsp_last;

    alu_op_scheduler #(.REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .i_req_op     (i_req_op),
        .i_req_tag    (i_req_tag),
        .o_alu_data_A (o_alu_data_A),
        .o_alu_data_B (o_alu_data_B),
        .o_alu_sel_op (o_alu_sel_op),
        .i_alu_data   (alu_q),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_tag    (o_rsp_tag),
        .o_rsp_op     (o_rsp_op),
        .o_busy       (o_busy),
        .o_issued_cnt (o_issued_cnt)
    );

    always #5 clk = ~clk;

    // The ALU itself: one register stage after the scheduler's operand flops.
    always @(posedge clk) begin
        if (o_alu_sel_op)
            alu_q <= 16'(o_alu_data_A) + 16'(o_alu_data_B);
        else
            alu_q <= 16'(o_alu_data_A) * 16'(o_alu_data_B);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic op, input logic [3:0] t);
        int   r;
        exp_t e;
        r = op ? (int'(a) + int'(b)) : (int'(a) * int'(b));
        e.d = r[15:0];
        e.t = t;
        e.o = op;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        if (!i_reset) begin
            if (o_rsp_valid && i_rsp_ready) begin
                if (n_rsp == 0) rsp_first = cyc;
                rsp_last = cyc;
                n_rsp++;
                chk("rsp_expected", 32'(mq.size() != 0), 32'd1);
                if (mq.size() != 0) begin
                    e = mq.pop_front();
                    chk("rsp_data", 32'(o_rsp_data), 32'(e.d));
                    chk("rsp_tag", 32'(o_rsp_tag), 32'(e.t));
                    chk("rsp_op", 32'(o_rsp_op), 32'(e.o));
                end
            end
            if (i_req_valid && o_req_ready)
                mq.push_back(mk(i_req_a, i_req_b, i_req_op, i_req_tag));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic [7:0] a, input logic [7:0] b,
                           input logic op, input logic [3:0] t);
        i_req_valid = 1'b1;
        i_req_a     = a;
        i_req_b     = b;
        i_req_op    = op;
        i_req_tag   = t;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic op, input logic [3:0] t);
        bit done = 0;
        set_req(a, b, op, t);
        for (int i = 0; i < 50 && !done; i++) begin
            done = o_req_ready;
            step();
        end
        chk("send_timeout", 32'(done), 32'd1);
        i_req_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            if (mq.size() == 0 && !o_busy) done = 1;
            else step();
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int k, acc, cnt0, nr0;
        bit fire;
        clk = 0;
        i_reset = 1;
        i_req_valid = 0;
        i_req_a = 0;
        i_req_b = 0;
        i_req_op = 0;
        i_req_tag = 0;
        i_rsp_ready = 0;
        step();
        step();
        chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
        chk("rst_rsp_data", 32'(o_rsp_data), 0);
        chk("rst_rsp_tag", 32'(o_rsp_tag), 0);
        chk("rst_rsp_op", 32'(o_rsp_op), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_cnt", 32'(o_issued_cnt), 0);
        chk("rst_alu", {8'h0, o_alu_data_A, o_alu_data_B, 7'h0, o_alu_sel_op}, 0);
        i_reset = 0;
        step();
        chk("rst_req_ready", 32'(o_req_ready), 1);

        // Single add with latency measurement
        i_rsp_ready = 1;
        set_req(8'd255, 8'd255, 1'b1, 4'd3);
        step();
        i_req_valid = 0;
        chk("lat_e0", 32'(o_rsp_valid), 0);
        step();
        chk("lat_e1", 32'(o_rsp_valid), 0);
        step();
        chk("lat_e2", 32'(o_rsp_valid), 0);
        step();
        chk("lat_e3", 32'(o_rsp_valid), 1);
        chk("add_data", 32'(o_rsp_data), 32'h01FE);
        chk("add_tag", 32'(o_rsp_tag), 3);
        chk("add_op", 32'(o_rsp_op), 1);
        drain(20);

        // Multiplies
        send(8'd200, 8'd200, 1'b0, 4'd5);
        drain(20);
        send(8'd0, 8'd77, 1'b0, 4'd6);
        drain(20);
        chk("mul_cnt", 32'(o_issued_cnt), 3);

        // Back-to-back stream, one response per cycle
        cnt0 = int'(o_issued_cnt);
        n_rsp = 0;
        for (int t = 0; t < 8; t++) begin
            set_req(8'($urandom), 8'($urandom), 1'(t), 4'(t));
            chk("b2b_ready", 32'(o_req_ready), 1);
            step();
        end
        i_req_valid = 0;
        drain(30);
        chk("b2b_nrsp", 32'(n_rsp), 8);
        chk("b2b_span", 32'(rsp_last - rsp_first), 7);
        chk("b2b_cnt", 32'(int'(o_issued_cnt) - cnt0), 8);

        // Backpressure: 4 results buffered, 4 requests queued
        i_rsp_ready = 0;
        n_rsp = 0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (k < 10) set_req(8'($urandom), 8'($urandom), 1'($urandom), 4'(k));
            else i_req_valid = 0;
            fire = i_req_valid && o_req_ready;
            step();
            if (fire) k++;
        end
        acc = k;
        chk("bp_accepted", 32'(acc), 8);
        chk("bp_req_ready", 32'(o_req_ready), 0);
        chk("bp_rsp_valid", 32'(o_rsp_valid), 1);
        chk("bp_nrsp", 32'(n_rsp), 0);
        i_rsp_ready = 1;
        for (int i = 0; i < 100 && k < 10; i++) begin
            set_req(8'($urandom), 8'($urandom), 1'($urandom), 4'(k));
            fire = o_req_ready;
            step();
            if (fire) k++;
        end
        i_req_valid = 0;
        drain(100);
        chk("bp_total", 32'(n_rsp), 10);
        chk("bp_model_empty", 32'(mq.size()), 0);

        // Reset with work queued and in flight
        for (int t = 0; t < 4; t++) begin
            set_req(8'($urandom), 8'($urandom), 1'($urandom), 4'(t + 8));
            step();
        end
        i_req_valid = 0;
        i_rsp_ready = 0;
        i_reset = 1;
        step();
        i_reset = 0;
        mq.delete();
        chk("mid_rst_valid", 32'(o_rsp_valid), 0);
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_cnt", 32'(o_issued_cnt), 0);
        i_rsp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_stale", 32'(o_rsp_valid), 0);
        end

        // Counter wrap after 65536 issues
        k = 0;
        for (int i = 0; i < 70000 && k < 65536; i++) begin
            set_req(8'($urandom), 8'($urandom), 1'($urandom), 4'(k));
            fire = o_req_ready;
            step();
            if (fire) k++;
            if (k == 100 && fire) chk("cnt_mid", 32'(o_issued_cnt) <= 32'd100, 1);
        end
        i_req_valid = 0;
        chk("wrap_sent", 32'(k), 32'd65536);
        drain(100);
        chk("wrap_cnt", 32'(o_issued_cnt), 0);
        chk("wrap_busy", 32'(o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
